// File: rtl/mips_data_mem.sv
// mips_data_mem
// Parametrised data-memory slave for the MIPS core. Accepts one access per
// req/ack handshake, with WAIT_CYCLES extra cycles between accept and
// completion. Supports byte, halfword and word loads and stores, sign or zero
// extension on loads, alignment and range error reporting, and a
// combinational debug read port.
//
// Parameters:
//   ADDR_WIDTH  - word-address bits; storage is 2^ADDR_WIDTH 32-bit words
//   WAIT_CYCLES - extra cycles between accept and completion (0..15)
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   mem_req    - access request, held by the core until mem_ack
//   mem_wen    - 1 = store, 0 = load
//   mem_size   - 00 byte, 01 halfword, 10 word, 11 reserved (error)
//   mem_sext   - loads: 1 = sign-extend, 0 = zero-extend
//   mem_addr   - byte address
//   mem_din    - store data, right-aligned
//   mem_dout   - load result, valid while mem_ack = 1, held until next ack
//   mem_ack    - one-cycle completion pulse
//   mem_err    - qualifies mem_ack: access rejected, storage untouched
//   mem_stall  - mem_req & ~mem_ack
//   debug_addr - debug word address
//   debug_data - storage[debug_addr], combinational
module mips_data_mem #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_wen,
  input  logic [1:0]            mem_size,
  input  logic                  mem_sext,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_din,
  output logic [31:0]           mem_dout,
  output logic                  mem_ack,
  output logic                  mem_err,
  output logic                  mem_stall,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  typedef struct packed {
    logic        wen;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] din;
  } req_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] storage [2**ADDR_WIDTH];

  state_t          state;
  logic [3:0]      cnt;
  req_t            live;
  req_t            latched;
  req_t            cur;
  logic            access;
  logic            acc_err;
  logic [ADDR_WIDTH-1:0] idx;
  logic [4:0]      lane_shift;
  logic [31:0]     rd_word;
  logic [31:0]     rd_shifted;
  logic [31:0]     wr_mask;
  logic [31:0]     wr_data;
  logic [31:0]     wr_word;
  logic [31:0]     ld_data;

  assign live = '{wen: mem_wen, size: mem_size, sext: mem_sext, addr: mem_addr, din: mem_din};

  // With zero wait cycles the access happens on the accept edge itself, so the
  // live request is used; otherwise the copy latched at accept drives it.
  assign cur = (state == ST_IDLE) ? live : latched;

  // Edge that enters DONE: this is where storage is written and dout captured.
  assign access = ((state == ST_IDLE) && mem_req && (WAIT_CYCLES == 0)) ||
                  ((state == ST_WAIT) && (cnt == 4'd0));

  assign idx        = cur.addr[ADDR_WIDTH+1:2];
  assign lane_shift = {cur.addr[1:0], 3'b000};
  assign rd_word    = storage[idx];
  assign rd_shifted = rd_word >> lane_shift;

  always_comb begin
    acc_err = 1'b0;
    if (cur.size == 2'b11)                               acc_err = 1'b1;
    if ((cur.size == SIZE_HALF) && cur.addr[0])          acc_err = 1'b1;
    if ((cur.size == SIZE_WORD) && (cur.addr[1:0] != 2'b00)) acc_err = 1'b1;
    if ((cur.addr >> (ADDR_WIDTH + 2)) != 32'd0)         acc_err = 1'b1;
  end

  // Store merge: only the addressed lanes change, the rest keep rd_word.
  always_comb begin
    wr_mask = 32'hFFFF_FFFF;
    wr_data = cur.din;
    case (cur.size)
      SIZE_BYTE: begin
        wr_mask = 32'h0000_00FF << lane_shift;
        wr_data = {24'd0, cur.din[7:0]} << lane_shift;
      end
      SIZE_HALF: begin
        wr_mask = 32'h0000_FFFF << lane_shift;
        wr_data = {16'd0, cur.din[15:0]} << lane_shift;
      end
      default: ;
    endcase
    wr_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
  end

  always_comb begin
    ld_data = rd_word;
    case (cur.size)
      SIZE_BYTE: ld_data = {{24{cur.sext & rd_shifted[7]}}, rd_shifted[7:0]};
      SIZE_HALF: ld_data = {{16{cur.sext & rd_shifted[15]}}, rd_shifted[15:0]};
      default:   ld_data = rd_word;
    endcase
  end

  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM;
  // gating the write with rst keeps an access that is reset at its commit edge
  // from landing.
  always_ff @(posedge clk) begin
    if (access && !acc_err && cur.wen && rst) begin
      storage[idx] <= wr_word;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of access/acc_err/ld_data consistently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      latched  <= '0;
      mem_ack  <= 1'b0;
      mem_err  <= 1'b0;
      mem_dout <= 32'd0;
    end else begin
      mem_ack <= access;
      if (access) begin
        mem_err  <= acc_err;
        mem_dout <= (acc_err || cur.wen) ? 32'd0 : ld_data;
      end
      case (state)
        ST_IDLE: begin
          if (mem_req) begin
            latched <= live;
            cnt     <= WAIT_LOAD;
            state   <= (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_stall  = mem_req & ~mem_ack;
  assign debug_data = storage[debug_addr];

endmodule
